// File: rtl/mul16_seq_if.sv
// Start/busy/done handshake between the CPU controller and the sequential multiplier.
// The controller holds the master modport; the multiplier holds the slave modport.
interface mul16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/mul16_seq.sv
// Iterative shift-and-add multiplier producing the low WIDTH bits of a*b.
// A single Add16 instance forms the accumulate path; zero multiplier bits end the run early.
module add16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);
  // The carry out of the top bit is dropped, so the sum wraps modulo 2^WIDTH.
  assign sum = x + y;
endmodule

module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mul16_seq_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;

  add16 #(.WIDTH(WIDTH)) u_add (
    .x   (acc),
    .y   (mcand),
    .sum (sum)
  );

  assign acc_next    = mplier[0] ? sum : acc;
  assign mplier_next = mplier >> 1;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values; the datapath registers are reset too so an
  // aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand    <= bus.a;
            mplier   <= bus.b;
            acc      <= '0;
            bus.busy <= 1'b1;
            // A zero multiplier needs no iterations: the product is already known.
            if (bus.b == '0) begin
              state      <= DONE;
              bus.done   <= 1'b1;
              bus.result <= '0;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          // Stop as soon as no multiplier bits remain; the last add is folded in.
          if (mplier_next == '0) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.result <= acc_next;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: expected products and latencies are queued at start
// and compared when done pulses.
module tb_mul16_seq;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          e0;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] prev_result;

  mul16_seq_if #(.WIDTH(16)) bus ();

  mul16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
    int n = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [15:0] exp_prod(input logic [15:0] av, input logic [15:0] bv);
    logic [31:0] full;
    full = {16'h0, av} * {16'h0, bv};
    return full[15:0];
  endfunction

  // Called just after a falling edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    e.prod = exp_prod(av, bv);
    e.lat  = exp_lat(bv);
    e.e0   = cyc;
    sb.push_back(e);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    check("busy_after_start", 16'(bus.busy), 16'd1);
    if (bv != 16'd0) check("result_held_on_start", bus.result, prev_result);
  endtask

  // Returns on the falling edge of the idle cycle that follows the done cycle.
  task automatic wait_done();
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 16'(bus.done), 16'd1);
    check("scoreboard_nonempty", 16'(sb.size() != 0), 16'd1);
    if (!bus.done || sb.size() == 0) begin
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("latency", 16'(cyc - e.e0), 16'(e.lat));
    check("result", bus.result, e.prod);
    check("busy_in_done", 16'(bus.busy), 16'd1);
    prev_result = e.prod;
    @(negedge clk);
    check("done_one_cycle", 16'(bus.done), 16'd0);
    check("busy_after_done", 16'(bus.busy), 16'd0);
    check("result_kept", bus.result, prev_result);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv);
    issue(av, bv);
    wait_done();
  endtask

  initial begin
    logic [15:0] fa;
    logic [15:0] fb;
    logic [15:0] ft;
    logic        saw_done;
    n_cmp       = 0;
    n_err       = 0;
    prev_result = 16'd0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.a       = 16'd0;
    bus.b       = 16'd0;

    #1;
    check("reset_busy", 16'(bus.busy), 16'd0);
    check("reset_done", 16'(bus.done), 16'd0);
    check("reset_result", bus.result, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5);
    run_op(16'hFFFD, 16'd7);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'h0100, 16'h0100);
    run_op(16'h1234, 16'h0000);
    run_op(16'h0000, 16'h8000);

    // A second request during RUN must be dropped, not queued.
    issue(16'd2, 16'h00FF);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd9;
    bus.b     = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    check("no_queued_done", 16'(bus.done), 16'd0);
    run_op(16'd9, 16'd9);

    // Abort mid-run with a short reset pulse.
    issue(16'd7, 16'h8001);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_done", 16'(bus.done), 16'd0);
    check("abort_result", bus.result, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    prev_result = 16'd0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 16'(saw_done), 16'd0);
    run_op(16'd6, 16'd7);

    // Fibonacci pairs issued back-to-back.
    fa = 16'd1;
    fb = 16'd1;
    while (fa < 16'd1024) begin
      run_op(fa, fb);
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
